serial_add_seq: RTL and testbench

Bit-serial adder sequencer that feeds the gate-level half-adder stage and consumes its outputs. It latches two WIDTH-bit operands on a start request and presents one bit pair per clock, LSB first, to a full adder. The full adder is two halfAdderGL instances plus an OR on the two carries. The sequencer registers the carry and shifts sum bits into a result register. It replaces the constant-driver stimulus with a real, clocked datapath for the Cu board.

---
 rtl/halfAdderGL.sv | 12 +
 rtl/serial_add_seq.sv | 100 ++++++++++
 tb/tb_serial_add_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/halfAdderGL.sv
// rtl/halfAdderGL.sv - gate-level half adder used as the serial full-adder building block
module halfAdderGL (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  xor g_sum   (s_o, a_i, b_i);
  and g_carry (c_o, a_i, b_i);

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial adder sequencer, LSB first, one bit pair per clock
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic s1, c1, fa_s, c2, fa_cout;

  halfAdderGL u_ha1 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .s_o(s1),   .c_o(c1));
  halfAdderGL u_ha2 (.a_i(s1),        .b_i(carry_q),   .s_o(fa_s), .c_o(c2));
  assign fa_cout = c1 | c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        // Visible result only moves on the final bit so sum/cout never show partial values.
        if (cnt_q == LAST_BIT) begin
          sum_d   = sum_sh_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - directed self-checking bench for serial_add_seq (WIDTH=8 and WIDTH=4)
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a, op_b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_a(a4), .op_b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 8-bit add from IDLE; optionally pulses start mid-SHIFT with other operands.
  task automatic run_add(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] prev_sum, input logic prev_cout,
                         input logic [7:0] exp_sum, input logic exp_cout,
                         input bit mid_start);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("shift_busy", busy, 1);
      check("shift_done_low", done, 0);
      check("shift_sum_hold", sum, prev_sum);
      check("shift_cout_hold", cout, prev_cout);
      if (mid_start && i == 3) begin
        op_a  = 8'h11;
        op_b  = 8'h22;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("result_sum", sum, exp_sum);
    check("result_cout", cout, exp_cout);
    step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_sum_hold", sum, exp_sum);
  endtask

  initial begin
    logic [4:0] exp5;
    int         cyc;
    int         last;
    bit         got;

    rst_n  = 1'b0;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    step();

    run_add(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add(8'hA5, 8'h5A, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_add(8'hC8, 8'h64, 8'hFF, 1'b0, 8'h2C, 1'b1, 1'b1);
    run_add(8'h01, 8'h02, 8'h2C, 1'b1, 8'h03, 1'b0, 1'b0);

    // Reset in the 4th SHIFT cycle aborts the add.
    op_a  = 8'h7F;
    op_b  = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_abort_no_done", done, 0);
      check("post_abort_idle", busy, 0);
    end
    run_add(8'h7F, 8'h01, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0);

    // WIDTH=4: all operand pairs under continuous start, done every 6 cycles.
    start4 = 1'b1;
    cyc    = 0;
    last   = 0;
    for (int p = 0; p < 256; p++) begin
      a4   = p[3:0];
      b4   = p[7:4];
      exp5 = 5'(p[3:0]) + 5'(p[7:4]);
      got  = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        step();
        cyc++;
        if (done4) begin
          got = 1'b1;
          check("w4_sum_cout", {cout4, sum4}, exp5);
          check("w4_busy_with_done", busy4, 1);
          if (p > 0) check("w4_done_spacing", cyc - last, 6);
          last = cyc;
        end
      end
      if (!got) check("w4_timeout", got, 1);
    end
    start4 = 1'b0;
    step();
    check("w4_no_double_done", done4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
